// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle between a producer/consumer and the serial adder.
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit gate-level full adder used as the serial adder's only arithmetic cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic out,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  xor g_x0 (ab_x, a, b);
  xor g_x1 (out, ab_x, cin);
  and g_a0 (ab_a, a, b);
  and g_a1 (cx_a, ab_x, cin);
  or  g_o0 (cout, ab_a, cx_a);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first through one full adder, WIDTH cycles per operation,
// valid/ready on both operand and result sides.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic          CLK,
  input  logic          RESET,
  serial_adder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             fa_out;
  logic             fa_cout;

  full_adder u_fa (
    .a    (op_a[0]),
    .b    (op_b[0]),
    .cin  (carry),
    .out  (fa_out),
    .cout (fa_cout)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)   state_d = RUN;
      RUN:     if (cnt == LAST)    state_d = DONE;
      DONE:    if (bus.out_ready)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      sum_q       <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            op_a  <= bus.a;
            op_b  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_q <= {fa_out, sum_q[WIDTH-1:1]};
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          carry <= fa_cout;
          // Hold at the last count so the counter never wraps mid-operation.
          if (cnt != LAST) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against an arithmetic (a + b + cin) reference.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Offer one operand set and wait until its result is presented; lat = edges after accept.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.a = x; bus.b = y; bus.cin = c; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    lat = (bus.out_valid === 1'b1) ? n : -1;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus.a = 8'hA5; bus.b = 8'h5A; bus.cin = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    checks++; if (bus.sum !== '0) begin errors++; $display("FAIL rst_sum got %h want 00", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL rst_cout got %b want 0", bus.cout); end
    rst = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b want 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [3] = '{8'h5A, 8'hFF, 8'hFF};
    logic [W-1:0] vb [3] = '{8'h33, 8'h01, 8'h00};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W:0]   exp;
    int lat;
    for (int i = 0; i < 3; i++) begin
      exp = ref_add(va[i], vb[i], vc[i]);
      do_op(va[i], vb[i], vc[i], lat);
      checks++; if (lat != int'(W)) begin errors++; $display("FAIL vec%0d_latency got %0d want %0d", i, lat, W); end
      checks++; if (bus.sum !== exp[W-1:0]) begin errors++; $display("FAIL vec%0d_sum got %h want %h", i, bus.sum, exp[W-1:0]); end
      checks++; if (bus.cout !== exp[W]) begin errors++; $display("FAIL vec%0d_cout got %b want %b", i, bus.cout, exp[W]); end
      checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL vec%0d_done_flags got busy=%b in_ready=%b want 1/0", i, bus.busy, bus.in_ready);
      end
      take();
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL vec%0d_return_idle got out_valid=%b in_ready=%b want 0/1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] exp;
    int lat;
    exp = ref_add(8'h10, 8'h20, 1'b0);
    do_op(8'h10, 8'h20, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.sum !== exp[W-1:0] || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got sum=%h ov=%b ir=%b want %h/1/0", i, bus.sum, bus.out_valid, bus.in_ready, exp[W-1:0]);
      end
      @(negedge clk);
    end
    take();
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL bp_release got in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset_abort();
    int seen_valid;
    int lat;
    logic [W:0] exp;
    @(negedge clk);
    bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_flags got ir=%b busy=%b ov=%b want 1/0/0", bus.in_ready, bus.busy, bus.out_valid);
    end
    checks++; if (bus.sum !== '0 || bus.cout !== 1'b0) begin
      errors++; $display("FAIL abort_sum got %h/%b want 00/0", bus.sum, bus.cout);
    end
    seen_valid = 0;
    for (int i = 0; i < int'(W) + 4; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen_valid++;
    end
    checks++; if (seen_valid != 0) begin errors++; $display("FAIL abort_no_valid got %0d pulses want 0", seen_valid); end
    exp = ref_add(8'h01, 8'h01, 1'b0);
    do_op(8'h01, 8'h01, 1'b0, lat);
    checks++; if (bus.sum !== exp[W-1:0] || lat != int'(W)) begin
      errors++; $display("FAIL abort_next got sum=%h lat=%0d want %h/%0d", bus.sum, lat, exp[W-1:0], W);
    end
    take();
  endtask

  task automatic test_ignore_during_run();
    logic [W-1:0] x, y;
    logic [W:0] exp;
    int n;
    int leaks;
    x = W'($urandom); y = W'($urandom);
    exp = ref_add(x, y, 1'b1);
    @(negedge clk);
    bus.a = x; bus.b = y; bus.cin = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    n = 0; leaks = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      if (bus.in_ready !== 1'b0) leaks++;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
      @(negedge clk);
      n++;
    end
    repeat (2) begin
      bus.a = W'($urandom); bus.b = W'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    checks++; if (leaks != 0) begin errors++; $display("FAIL ignore_in_ready got %0d high cycles want 0", leaks); end
    checks++; if (bus.out_valid !== 1'b1 || bus.sum !== exp[W-1:0] || bus.cout !== exp[W]) begin
      errors++; $display("FAIL ignore_result got ov=%b %b_%h want 1 %b_%h", bus.out_valid, bus.cout, bus.sum, exp[W], exp[W-1:0]);
    end
    take();
  endtask

  task automatic test_back_to_back();
    logic [W:0] exp_q[$];
    int accept_t[$];
    logic [W:0] e;
    int results;
    int cyc;
    results = 0; cyc = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    while ((accept_t.size() < 5 || results < 5) && cyc < 300) begin
      if (bus.out_valid === 1'b1) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        results++;
        checks++; if (bus.sum !== e[W-1:0] || bus.cout !== e[W]) begin
          errors++; $display("FAIL b2b_result%0d got %b_%h want %b_%h", results, bus.cout, bus.sum, e[W], e[W-1:0]);
        end
      end
      if (bus.in_ready === 1'b1 && accept_t.size() < 5) begin
        bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        bus.in_valid = 1'b1;
        exp_q.push_back(ref_add(bus.a, bus.b, bus.cin));
        accept_t.push_back(cyc);
      end else if (bus.in_ready === 1'b1) begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (results != 5) begin errors++; $display("FAIL b2b_count got %0d results want 5", results); end
    for (int i = 1; i < accept_t.size(); i++) begin
      checks++; if (accept_t[i] - accept_t[i-1] != int'(W) + 2) begin
        errors++; $display("FAIL b2b_gap%0d got %0d want %0d", i, accept_t[i] - accept_t[i-1], W + 2);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic c;
    logic [W:0] exp;
    int lat;
    int stall;
    for (int i = 0; i < 20; i++) begin
      x = W'($urandom); y = W'($urandom); c = 1'($urandom);
      stall = int'($urandom_range(0, 3));
      exp = ref_add(x, y, c);
      do_op(x, y, c, lat);
      repeat (stall) @(negedge clk);
      checks++;
      if (lat != int'(W) || bus.sum !== exp[W-1:0] || bus.cout !== exp[W] || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d got lat=%0d %b_%h ov=%b want %0d %b_%h 1", i, lat, bus.cout, bus.sum, bus.out_valid, W, exp[W], exp[W-1:0]);
      end
      take();
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    rst = 1'b1;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_abort();
    test_ignore_during_run();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
